// File: rtl/sparse24_weight_packer_pkg.sv
// Shared constants and FSM encoding for the 2:4 structured-sparse weight packer.
package sparse_pkg;
    localparam int GROUP = 4;
    localparam int NNZ   = 2;
    localparam int IDXW  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/sparse24_weight_packer_if.sv
// Dense-row handshake plus packed row-load outputs; master = packer, slave = source/row side.
interface sparse24_weight_packer_if #(
    parameter int col = 4,
    parameter int bw  = 4
);
    import sparse_pkg::*;

    logic                         dense_valid;
    logic                         dense_ready;
    logic [col*GROUP*bw-1:0]      dense_flat;
    logic [col*NNZ*bw-1:0]        weights_flat;
    logic [col*GROUP-1:0]         weight_mask;
    logic [col*NNZ*IDXW-1:0]      index_flat;
    logic                         load;
    logic                         busy;
    logic                         overflow;
    logic                         overflow_clr;

    modport master (
        input  dense_valid, dense_flat, overflow_clr,
        output dense_ready, weights_flat, weight_mask, index_flat, load, busy, overflow
    );

    modport slave (
        output dense_valid, dense_flat, overflow_clr,
        input  dense_ready, weights_flat, weight_mask, index_flat, load, busy, overflow
    );
endinterface

// File: rtl/sparse24_group_compress.sv
// Combinational 2:4 compression of one 4-lane group: keeps the two lowest-lane nonzeros.
module sparse24_group_compress
    import sparse_pkg::*;
#(
    parameter int bw = 4
) (
    input  logic [GROUP*bw-1:0]  grp,
    output logic [NNZ*bw-1:0]    vals,
    output logic [GROUP-1:0]     mask,
    output logic [NNZ*IDXW-1:0]  idx,
    output logic                 over
);
    always_comb begin
        int nz;
        nz   = 0;
        vals = '0;
        mask = '0;
        idx  = '0;
        over = 1'b0;
        for (int k = 0; k < GROUP; k++) begin
            if (grp[k*bw +: bw] != '0) begin
                if (nz < NNZ) begin
                    vals[nz*bw +: bw]     = grp[k*bw +: bw];
                    idx[nz*IDXW +: IDXW]  = IDXW'(k);
                    mask[k]               = 1'b1;
                    nz                    = nz + 1;
                end else begin
                    over = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/sparse24_weight_packer.sv
// Accepts a dense row, registers its 2:4 compressed form, strobes load once, then holds
// outputs for hold_cycles so the row's load pipeline can consume them.
module sparse24_weight_packer
    import sparse_pkg::*;
#(
    parameter int col         = 4,
    parameter int bw          = 4,
    parameter int nnz_per_col = 2,
    parameter int hold_cycles = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    sparse24_weight_packer_if.master bus
);
    localparam int WW = col*nnz_per_col*bw;
    localparam int MW = col*GROUP;
    localparam int IW = col*NNZ*IDXW;
    localparam int CW = (hold_cycles > 1) ? $clog2(hold_cycles) : 1;

    logic [WW-1:0]  c_vals;
    logic [MW-1:0]  c_mask;
    logic [IW-1:0]  c_idx;
    logic [col-1:0] c_over;

    for (genvar c = 0; c < col; c++) begin : g_col
        sparse24_group_compress #(.bw(bw)) u_grp (
            .grp  (bus.dense_flat[c*GROUP*bw +: GROUP*bw]),
            .vals (c_vals[c*NNZ*bw +: NNZ*bw]),
            .mask (c_mask[c*GROUP +: GROUP]),
            .idx  (c_idx[c*NNZ*IDXW +: NNZ*IDXW]),
            .over (c_over[c])
        );
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          load_q, load_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic [WW-1:0] weights_q, weights_d;
    logic [MW-1:0] mask_q, mask_d;
    logic [IW-1:0] index_q, index_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        load_d    = 1'b0;
        busy_d    = busy_q;
        weights_d = weights_q;
        mask_d    = mask_q;
        index_d   = index_q;
        // A new overflow event in the accept cycle overrides a simultaneous clear.
        ovf_d     = bus.overflow_clr ? 1'b0 : ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.dense_valid) begin
                    state_d   = ISSUE;
                    load_d    = 1'b1;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                    weights_d = c_vals;
                    mask_d    = c_mask;
                    index_d   = c_idx;
                    if (|c_over) ovf_d = 1'b1;
                end
            end
            ISSUE: begin
                if (hold_cycles == 0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    state_d = HOLD;
                    cnt_d   = CW'(hold_cycles - 1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            weights_q <= '0;
            mask_q    <= '0;
            index_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            weights_q <= weights_d;
            mask_q    <= mask_d;
            index_q   <= index_d;
        end
    end

    assign bus.dense_ready  = ready_q;
    assign bus.load         = load_q;
    assign bus.busy         = busy_q;
    assign bus.overflow     = ovf_q;
    assign bus.weights_flat = weights_q;
    assign bus.weight_mask  = mask_q;
    assign bus.index_flat   = index_q;
endmodule

// File: tb/tb_sparse24_weight_packer.sv
// Scoreboard bench: driver pushes model results on accept, monitor pops on every load strobe.
module tb_sparse24_weight_packer;
    import sparse_pkg::*;

    localparam int COL = 4;
    localparam int BW  = 4;
    localparam int DW  = COL*4*BW;
    localparam int WW  = COL*2*BW;
    localparam int MW  = COL*4;
    localparam int IW  = COL*4;

    typedef struct {
        logic [WW-1:0] w;
        logic [MW-1:0] m;
        logic [IW-1:0] idx;
        logic          over;
        logic          ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic model_ovf = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sparse24_weight_packer_if #(.col(COL), .bw(BW)) bus();

    sparse24_weight_packer #(.col(COL), .bw(BW), .nnz_per_col(2), .hold_cycles(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: per column, list the nonzero lanes and keep the first two of that list.
    function automatic exp_t model(input logic [DW-1:0] row);
        exp_t e;
        e.w = '0; e.m = '0; e.idx = '0; e.over = 1'b0; e.ovf = 1'b0;
        for (int c = 0; c < COL; c++) begin
            int lanes[$];
            lanes = {};
            for (int k = 0; k < 4; k++)
                if (row[(c*4+k)*BW +: BW] != '0) lanes.push_back(k);
            for (int s = 0; s < 2 && s < lanes.size(); s++) begin
                e.w[(c*2+s)*BW +: BW] = row[(c*4+lanes[s])*BW +: BW];
                e.m[c*4+lanes[s]]     = 1'b1;
                e.idx[(c*2+s)*2 +: 2] = 2'(lanes[s]);
            end
            if (lanes.size() > 2) e.over = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [DW-1:0] rand_row(input int density);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < COL*4; i++)
            if ($urandom_range(0, 99) < density) r[i*BW +: BW] = BW'($urandom_range(1, 15));
        return r;
    endfunction

    function automatic logic [DW-1:0] clean_row();
        logic [DW-1:0] r;
        r = '0;
        for (int c = 0; c < COL; c++) begin
            r[(c*4+1)*BW +: BW] = BW'($urandom_range(0, 15));
            r[(c*4+3)*BW +: BW] = BW'($urandom_range(0, 15));
        end
        return r;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!bus.dense_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", bus.dense_ready, 1);
    endtask

    // Called at a negedge where dense_ready is high: the next posedge accepts.
    task automatic accept(input logic [DW-1:0] row, input logic clr);
        exp_t e;
        bus.dense_valid  = 1'b1;
        bus.dense_flat   = row;
        bus.overflow_clr = clr;
        e = model(row);
        e.ovf = (model_ovf && !clr) || e.over;
        model_ovf = e.ovf;
        sb.push_back(e);
    endtask

    task automatic send(input logic [DW-1:0] row, input logic clr);
        @(negedge clk);
        wait_ready();
        accept(row, clr);
        @(negedge clk);
        bus.dense_valid  = 1'b0;
        bus.overflow_clr = 1'b0;
        chk("load_latency", bus.load, 1);
    endtask

    task automatic clear_ovf();
        @(negedge clk);
        bus.overflow_clr = 1'b1;
        @(negedge clk);
        bus.overflow_clr = 1'b0;
        model_ovf = 1'b0;
        chk("ovf_cleared", bus.overflow, 0);
    endtask

    // Monitor: check each load against the scoreboard and output stability during hold.
    logic          prev_load = 1'b0;
    logic [WW-1:0] hold_w;
    logic [MW-1:0] hold_m;
    logic [IW-1:0] hold_i;
    always @(negedge clk) begin
        if (reset) begin
            prev_load <= 1'b0;
        end else begin
            if (bus.load) begin
                chk("load_single_cycle", prev_load, 0);
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("weights_flat", bus.weights_flat, e.w);
                    chk("weight_mask", bus.weight_mask, e.m);
                    chk("index_flat", bus.index_flat, e.idx);
                    chk("overflow", bus.overflow, e.ovf);
                end
                chk("busy_in_issue", bus.busy, 1);
                hold_w <= bus.weights_flat;
                hold_m <= bus.weight_mask;
                hold_i <= bus.index_flat;
            end else if (bus.busy) begin
                chk("hold_weights", bus.weights_flat, hold_w);
                chk("hold_mask", bus.weight_mask, hold_m);
                chk("hold_index", bus.index_flat, hold_i);
                chk("hold_not_ready", bus.dense_ready, 0);
            end
            prev_load <= bus.load;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int last;
        bus.dense_valid  = 1'b0;
        bus.dense_flat   = '0;
        bus.overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.dense_ready, 1);
        chk("rst_load", bus.load, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_weights", bus.weights_flat, 0);
        chk("rst_mask", bus.weight_mask, 0);
        chk("rst_index", bus.index_flat, 0);
        reset = 1'b0;

        // Column 0 lanes {0,3,0,-2}.
        send(64'h0000_0000_0000_E030, 1'b0);
        chk("d1_weights", bus.weights_flat, 32'h0000_00E3);
        chk("d1_mask", bus.weight_mask, 16'h000A);
        chk("d1_index", bus.index_flat, 16'h000D);
        chk("d1_ovf", bus.overflow, 0);

        send('0, 1'b0);
        chk("zero_weights", bus.weights_flat, 0);
        chk("zero_mask", bus.weight_mask, 0);
        chk("zero_index", bus.index_flat, 0);
        n = 0;
        while (bus.busy && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, 3);

        // Column 0 lanes {5,6,7,0}: third nonzero dropped, sticky overflow.
        send(64'h0000_0000_0000_0765, 1'b0);
        chk("ov_weights", bus.weights_flat, 32'h0000_0065);
        chk("ov_mask", bus.weight_mask, 16'h0003);
        chk("ov_index", bus.index_flat, 16'h0004);
        chk("ov_set", bus.overflow, 1);
        send(clean_row(), 1'b0);
        chk("ov_sticky1", bus.overflow, 1);
        send(clean_row(), 1'b0);
        chk("ov_sticky2", bus.overflow, 1);
        clear_ovf();

        send(64'h0000_0000_0000_0765, 1'b1);
        chk("ov_set_wins", bus.overflow, 1);
        clear_ovf();

        // dense_valid held high: accepts 4 cycles apart.
        @(negedge clk);
        last = 0;
        for (int i = 0; i < 6; i++) begin
            wait_ready();
            if (i > 0) chk("burst_gap", cyc - last, 4);
            last = cyc;
            accept(rand_row(60), 1'b0);
            @(negedge clk);
            chk("burst_load", bus.load, 1);
        end
        bus.dense_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(rand_row(50), $urandom_range(0, 9) == 0);
        end

        // Reset in the first HOLD cycle.
        send(rand_row(70), 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_ovf = 1'b0;
        chk("mid_rst_ready", bus.dense_ready, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_load", bus.load, 0);
        chk("mid_rst_ovf", bus.overflow, 0);
        chk("mid_rst_weights", bus.weights_flat, 0);
        chk("mid_rst_mask", bus.weight_mask, 0);
        chk("mid_rst_index", bus.index_flat, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_no_load", bus.load, 0);

        send(rand_row(50), 1'b0);
        repeat (6) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sparse24_weight_packer.md
Name: sparse24_weight_packer

Overview:
Producer side of the sparse row weight interface. Accepts dense weight rows, groups of 4 weights per column, over a valid/ready handshake. Compresses each group to 2:4 structured-sparse form: 2 packed values, a 4-bit occupancy mask and two 2-bit indices. Drives the row's weight and mask inputs and issues a single-cycle load strobe, then holds the outputs stable until the row's internal load pipeline has consumed them.

Parameters:
col, 4, number of columns per row (groups of 4 dense weights)
bw, 4, weight bit width (two's complement)
nnz_per_col, 2, packed values per column (fixed at 2; other values are not supported)
hold_cycles, 2, cycles the outputs stay stable after the load strobe (covers the row's 2-stage load delay)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dense_valid  in  1  dense row available
dense_ready  out  1  packer can accept a row
dense_flat  in  col*4*bw  dense weights; column c, lane k at [(c*4+k)*bw +: bw]
weights_flat  out  col*2*bw  packed values; column c, slot s at [(c*2+s)*bw +: bw]
weight_mask  out  col*4  occupancy mask; bit c*4+k set means lane k is kept
index_flat  out  col*4  two 2-bit lane indices per column; slot s at [(c*2+s)*2 +: 2]
load  out  1  one-cycle strobe to the row
busy  out  1  high from accept until the hold completes
overflow  out  1  sticky: some group had more than 2 nonzeros
overflow_clr  in  1  clears overflow

Behaviour:
- Reset: dense_ready=1 in IDLE; load=0; busy=0; overflow=0; weights_flat, weight_mask and index_flat are all zero.
- FSM states are IDLE, ISSUE and HOLD.
- IDLE:
  - dense_ready=1.
  - When dense_valid=1, the row is accepted, all columns are compressed combinationally and the results are registered. The FSM then moves to ISSUE.
- ISSUE (exactly 1 cycle):
  - load=1, busy=1, dense_ready=0.
  - The packed outputs are valid this cycle. This is the cycle after the accept, so latency is 1.
- HOLD:
  - An internal counter counts hold_cycles cycles. load=0 and the outputs stay stable.
  - When the count is exhausted, the FSM returns to IDLE. dense_ready rises in the same cycle the FSM enters IDLE.
  - Throughput: one row per 2+hold_cycles cycles.
- Compression per column, nonzero meaning value != 0:
  - Scan lanes 0 to 3 in ascending order. The first nonzero goes to slot 0 and the second to slot 1.
  - The mask has a bit set for each kept lane.
  - Indices hold the kept lane numbers.
- Fewer than 2 nonzeros:
  - Each unused slot gets value 0 and index 0, and no mask bit is set for it.
  - An all-zero group gives mask 0000, values 0 and indices 0.
- More than 2 nonzeros:
  - The two lowest-index nonzeros are kept and the rest are dropped.
  - overflow is set 1 cycle after the accept, i.e. in the ISSUE cycle.
- overflow is sticky:
  - It is cleared by overflow_clr or reset.
  - If overflow_clr and a new overflow event occur in the same cycle, the set wins.
- Output registers update only on accept; they keep their value through IDLE.
- dense_valid is ignored outside IDLE. The source must hold dense_flat stable while valid=1 and ready=0.
- Reset asserted mid-ISSUE or mid-HOLD: next cycle the FSM is in IDLE with all outputs at their reset values, and no load strobe is produced.
- No arithmetic is performed; values are passed bit-exact, signed.

Decomposition:
- Shared package sparse_pkg holds:
  - constant GROUP=4
  - constant NNZ=2
  - the FSM state enum (IDLE/ISSUE/HOLD)
  - the index width constant IDXW=2
- One sub-module, sparse24_group_compress: combinational, per column; takes 4*bw in and gives 2*bw values, 4-bit mask, 4-bit indices and an over flag. Instantiated col times via generate.

Test Plan:
- Dense column lanes {0,3,0,-2} (lane0..3), bw=4 -> slot0=3, idx0=1; slot1=-2 (4'hE), idx1=3; mask=1010 (bits k=1,3 set); load high exactly 1 cycle after accept; overflow=0.
- All-zero row, col=4 -> weights_flat=0, weight_mask=0, index_flat=0; load still pulses once; busy high for 1+hold_cycles cycles.
- Column {5,6,7,0} -> keeps 5 (idx0) and 6 (idx1), mask=0011, overflow=1 from the ISSUE cycle; it stays 1 across two further clean rows until overflow_clr.
- dense_valid held high continuously -> accepts spaced 4 cycles apart (hold_cycles=2); exactly one load per accept; outputs stable across all HOLD cycles.
- reset asserted in the HOLD cycle -> next cycle dense_ready=1, busy=0, all outputs zero; no extra load.
- overflow_clr asserted in the same cycle as an overflowing group sets overflow -> overflow stays 1.
